can_tx_frame: RTL and testbench

CAN_TX_FRAME -- requirements
Module: can_tx_frame

---
 rtl/can_tx_frame.sv | 236 +++++++++++++++++++++++
 tb/tb_can_tx_frame.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_frame.sv
// rtl/can_tx_frame.sv - CAN 2.0A frame transmitter with bit stuffing, CRC-15 and readback checking
module can_tx_frame #(
    parameter int clk_speed_MHz      = 100,
    parameter int can_bit_rate_Kbits = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [10:0] tx_id,
    input  logic        tx_rtr,
    input  logic [3:0]  tx_dlc,
    input  logic [63:0] tx_data,
    input  logic        rx_din,
    output logic        tx_dout,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        arb_lost,
    output logic        ack_err,
    output logic        bit_err
);
    localparam int BIT_CLKS = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
    localparam int SP       = BIT_CLKS * 7 / 10;
    localparam int TW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_CLKS - 1);
    localparam logic [TW-1:0] TICK_SP   = TW'(SP);

    typedef enum logic [3:0] {
        S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC,
        S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS
    } state_t;

    state_t        r_state, w_state;
    logic [TW-1:0] r_tick, w_tick;
    logic [6:0]    r_cnt, w_cnt;
    logic [17:0]   r_hdr, w_hdr;
    logic [6:0]    r_nbits, w_nbits;
    logic [63:0]   r_data, w_data;
    logic [14:0]   r_crc, w_crc;
    logic [2:0]    r_run, w_run;
    logic          r_last, w_last;
    logic          r_tx_dout, w_dout;
    logic          r_done, w_done;
    logic          r_arb, w_arb;
    logic          r_ack, w_ack;
    logic          r_berr, w_berr;
    logic          w_bit;
    logic          w_crc_en;
    logic          w_in_stuff;

    function automatic logic [14:0] f_crc(input logic [14:0] c, input logic b);
        f_crc = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0000);
    endfunction

    assign w_in_stuff = r_state inside {S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC};

    // Invariant: r_hdr[17], r_data[63] and r_crc[14] hold the field bit currently on the wire.
    always_comb begin
        w_state  = r_state;
        w_tick   = r_tick;
        w_cnt    = r_cnt;
        w_hdr    = r_hdr;
        w_nbits  = r_nbits;
        w_data   = r_data;
        w_crc    = r_crc;
        w_run    = r_run;
        w_last   = r_last;
        w_dout   = r_tx_dout;
        w_done   = 1'b0;
        w_arb    = 1'b0;
        w_ack    = 1'b0;
        w_berr   = 1'b0;
        w_bit    = 1'b1;
        w_crc_en = 1'b0;
        if (r_state == S_IDLE) begin
            w_tick = '0;
            w_dout = 1'b1;
            if (tx_start) begin
                w_state = S_SOF;
                w_dout  = 1'b0;
                w_cnt   = '0;
                w_hdr   = {tx_id, tx_rtr, 2'b00, tx_dlc};
                w_nbits = tx_rtr ? 7'd0 : ((tx_dlc > 4'd8) ? 7'd64 : {tx_dlc, 3'b000});
                w_data  = tx_data;
                w_crc   = '0;
                w_run   = 3'd1;
                w_last  = 1'b0;
            end
        end else if (r_tick == TICK_SP) begin
            w_tick = r_tick + 1'b1;
            case (r_state)
                S_ARB: begin
                    w_arb  = r_tx_dout & ~rx_din;
                    w_berr = ~r_tx_dout & rx_din;
                end
                S_ACK_SLOT: w_ack  = rx_din;
                S_IFS:      w_berr = 1'b0;
                default:    w_berr = rx_din ^ r_tx_dout;
            endcase
            if (w_arb | w_ack | w_berr) begin
                w_state = S_IDLE;
                w_tick  = '0;
                w_dout  = 1'b1;
            end
        end else if (r_tick != TICK_LAST) begin
            w_tick = r_tick + 1'b1;
        end else begin
            w_tick = '0;
            if (w_in_stuff && r_run == 3'd5) begin
                // Stuff bit: field pointer holds, CRC untouched.
                w_dout = ~r_last;
                w_last = ~r_last;
                w_run  = 3'd1;
            end else begin
                case (r_state)
                    S_SOF: begin
                        w_state  = S_ARB;
                        w_cnt    = '0;
                        w_bit    = r_hdr[17];
                        w_crc_en = 1'b1;
                    end
                    S_ARB, S_CTRL: begin
                        w_bit    = r_hdr[16];
                        w_hdr    = {r_hdr[16:0], 1'b0};
                        w_crc_en = 1'b1;
                        w_cnt    = r_cnt + 7'd1;
                        if (r_state == S_ARB && r_cnt == 7'd11) begin
                            w_state = S_CTRL;
                            w_cnt   = '0;
                        end else if (r_state == S_CTRL && r_cnt == 7'd5) begin
                            w_cnt = '0;
                            if (r_nbits != 7'd0) begin
                                w_state = S_DATA;
                                w_bit   = r_data[63];
                            end else begin
                                w_state  = S_CRC;
                                w_bit    = r_crc[14];
                                w_crc_en = 1'b0;
                            end
                        end
                    end
                    S_DATA: begin
                        if (r_cnt == r_nbits - 7'd1) begin
                            w_state = S_CRC;
                            w_cnt   = '0;
                            w_bit   = r_crc[14];
                        end else begin
                            w_bit    = r_data[62];
                            w_data   = {r_data[62:0], 1'b0};
                            w_cnt    = r_cnt + 7'd1;
                            w_crc_en = 1'b1;
                        end
                    end
                    S_CRC: begin
                        if (r_cnt == 7'd14) begin
                            w_state = S_CRC_DEL;
                        end else begin
                            w_bit = r_crc[13];
                            w_crc = {r_crc[13:0], 1'b0};
                            w_cnt = r_cnt + 7'd1;
                        end
                    end
                    S_CRC_DEL:  w_state = S_ACK_SLOT;
                    S_ACK_SLOT: w_state = S_ACK_DEL;
                    S_ACK_DEL: begin
                        w_state = S_EOF;
                        w_cnt   = '0;
                    end
                    S_EOF: begin
                        w_cnt = r_cnt + 7'd1;
                        if (r_cnt == 7'd6) begin
                            w_state = S_IFS;
                            w_cnt   = '0;
                        end
                    end
                    S_IFS: begin
                        w_cnt = r_cnt + 7'd1;
                        if (r_cnt == 7'd2) begin
                            w_state = S_IDLE;
                            w_done  = 1'b1;
                        end
                    end
                    default: w_state = S_IDLE;
                endcase
                w_dout = w_bit;
                if (w_crc_en) begin
                    w_crc = f_crc(r_crc, w_bit);
                end
                if (w_state inside {S_ARB, S_CTRL, S_DATA, S_CRC}) begin
                    w_run  = (w_bit == r_last) ? r_run + 3'd1 : 3'd1;
                    w_last = w_bit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_cnt     <= '0;
            r_hdr     <= '0;
            r_nbits   <= '0;
            r_data    <= '0;
            r_crc     <= '0;
            r_run     <= '0;
            r_last    <= 1'b0;
            r_tx_dout <= 1'b1;
            r_done    <= 1'b0;
            r_arb     <= 1'b0;
            r_ack     <= 1'b0;
            r_berr    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_tick    <= w_tick;
            r_cnt     <= w_cnt;
            r_hdr     <= w_hdr;
            r_nbits   <= w_nbits;
            r_data    <= w_data;
            r_crc     <= w_crc;
            r_run     <= w_run;
            r_last    <= w_last;
            r_tx_dout <= w_dout;
            r_done    <= w_done;
            r_arb     <= w_arb;
            r_ack     <= w_ack;
            r_berr    <= w_berr;
        end
    end

    assign tx_dout  = r_tx_dout;
    assign tx_busy  = (r_state != S_IDLE);
    assign tx_done  = r_done;
    assign arb_lost = r_arb;
    assign ack_err  = r_ack;
    assign bit_err  = r_berr;
endmodule

// File: tb/tb_can_tx_frame.sv
// tb/tb_can_tx_frame.sv - randomized self-checking bench for can_tx_frame against a frame-level model
module tb_can_tx_frame;
    localparam int K_DONE = 0;
    localparam int K_ARB  = 1;
    localparam int K_ACK  = 2;
    localparam int K_BIT  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_start;
    logic [10:0] tx_id;
    logic        tx_rtr;
    logic [3:0]  tx_dlc;
    logic [63:0] tx_data;
    logic        rx_din;
    logic        tx_dout, tx_busy, tx_done, arb_lost, ack_err, bit_err;
    logic        ovr_en, ovr_val;

    int n_checks = 0;
    int n_fail   = 0;
    bit m_wire[$];
    int m_map[$];
    int m_ack;
    bit m_obs[$];

    always #5 clk = ~clk;

    // Bus readback: loopback unless the bench overrides the current bit.
    assign rx_din = ovr_en ? ovr_val : tx_dout;

    can_tx_frame dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_id(tx_id), .tx_rtr(tx_rtr),
        .tx_dlc(tx_dlc), .tx_data(tx_data), .rx_din(rx_din), .tx_dout(tx_dout),
        .tx_busy(tx_busy), .tx_done(tx_done), .arb_lost(arb_lost), .ack_err(ack_err),
        .bit_err(bit_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_model(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                               input logic [63:0] data);
        bit          raw[$];
        logic [14:0] crc;
        int          nb;
        int          run;
        bit          last;
        bit          fb;
        m_wire.delete();
        m_map.delete();
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = rtr ? 0 : 8 * ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < nb; i++) raw.push_back(data[63-i]);
        crc = '0;
        foreach (raw[i]) begin
            fb  = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (fb) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        run  = 0;
        last = 1'b0;
        foreach (raw[i]) begin
            m_map.push_back(m_wire.size());
            m_wire.push_back(raw[i]);
            if (run > 0 && raw[i] == last) run++;
            else run = 1;
            last = raw[i];
            if (run == 5) begin
                m_wire.push_back(!last);
                last = !last;
                run  = 1;
            end
        end
        m_wire.push_back(1'b1);
        m_ack = m_wire.size();
        repeat (12) m_wire.push_back(1'b1);
    endtask

    task automatic run_frame(input string name, input logic [10:0] id, input logic rtr,
                             input logic [3:0] dlc, input logic [63:0] data, input int force_pos,
                             input bit force_val, input bit ack_ok, input int kind);
        int fw, end_c, k, t;
        int n_d, n_a, n_k, n_b, c_pulse, busy_fall, n_low_after;
        build_model(id, rtr, dlc, data);
        m_obs.delete();
        fw = (force_pos >= 0) ? m_map[force_pos] : -1;
        case (kind)
            K_DONE:  end_c = m_wire.size() * 100;
            K_ACK:   end_c = m_ack * 100 + 71;
            default: end_c = fw * 100 + 71;
        endcase
        n_d = 0; n_a = 0; n_k = 0; n_b = 0;
        c_pulse = -1; busy_fall = -1; n_low_after = 0;
        @(negedge clk);
        tx_id = id; tx_rtr = rtr; tx_dlc = dlc; tx_data = data; tx_start = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= end_c + 5; c++) begin
            @(negedge clk);
            k = c / 100;
            t = c % 100;
            if (c == 0) begin
                tx_start = 1'b0;
                tx_id = 11'($urandom); tx_rtr = 1'($urandom);
                tx_dlc = 4'($urandom); tx_data = {$urandom, $urandom};
                check_eq({name, " busy_at_sof"}, tx_busy, 1'b1);
                check_eq({name, " dout_at_sof"}, tx_dout, 1'b0);
            end
            if (c == 250) tx_start = 1'b1;
            if (c == 251) tx_start = 1'b0;
            if (t == 0) begin
                ovr_en = 1'b0;
                if (k == fw) begin
                    ovr_en = 1'b1; ovr_val = force_val;
                end
                if (k == m_ack && ack_ok) begin
                    ovr_en = 1'b1; ovr_val = 1'b0;
                end
            end
            if (t == 50 && c < end_c && k < m_wire.size()) begin
                m_obs.push_back(tx_dout);
                check_eq($sformatf("%s bit%0d", name, k), tx_dout, m_wire[k]);
            end
            if (tx_done)  begin n_d++; c_pulse = c; end
            if (arb_lost) begin n_a++; c_pulse = c; end
            if (ack_err)  begin n_k++; c_pulse = c; end
            if (bit_err)  begin n_b++; c_pulse = c; end
            if (!tx_busy && busy_fall < 0) busy_fall = c;
            if (c >= end_c && !tx_dout) n_low_after++;
        end
        ovr_en = 1'b0;
        check_eq({name, " done_cnt"}, n_d, (kind == K_DONE) ? 1 : 0);
        check_eq({name, " arb_cnt"},  n_a, (kind == K_ARB)  ? 1 : 0);
        check_eq({name, " ack_cnt"},  n_k, (kind == K_ACK)  ? 1 : 0);
        check_eq({name, " bit_cnt"},  n_b, (kind == K_BIT)  ? 1 : 0);
        check_eq({name, " pulse_cycle"}, c_pulse, end_c);
        check_eq({name, " busy_fall"}, busy_fall, end_c);
        check_eq({name, " idle_recessive"}, n_low_after, 0);
    endtask

    task automatic reset_mid_data();
        int n_p, n_low;
        @(negedge clk);
        tx_id = 11'($urandom); tx_rtr = 1'b0; tx_dlc = 4'd8; tx_data = {$urandom, $urandom};
        tx_start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 3050; c++) begin
            @(negedge clk);
            tx_start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rstmid_dout", tx_dout, 1'b1);
        check_eq("rstmid_busy", tx_busy, 1'b0);
        check_eq("rstmid_pulses", {tx_done, arb_lost, ack_err, bit_err}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        n_p = 0; n_low = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx_done | arb_lost | ack_err | bit_err) n_p++;
            if (!tx_dout || tx_busy) n_low++;
        end
        check_eq("rstmid_no_pulse", n_p, 0);
        check_eq("rstmid_quiet", n_low, 0);
    endtask

    initial begin
        rst_n = 1'b0; tx_start = 1'b0; tx_id = '0; tx_rtr = 1'b0; tx_dlc = '0; tx_data = '0;
        ovr_en = 1'b0; ovr_val = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_dout", tx_dout, 1'b1);
        check_eq("rst_busy", tx_busy, 1'b0);
        check_eq("rst_pulses", {tx_done, arb_lost, ack_err, bit_err}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame("f123", 11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, -1, 1'b0, 1'b1, K_DONE);
        run_frame("f000", 11'h000, 1'b0, 4'd0, 64'h0, -1, 1'b0, 1'b1, K_DONE);
        check_eq("stuff_after_sof", (m_obs.size() > 5) ? m_obs[5] : 1'b0, 1'b1);
        run_frame("arb", 11'h7FF, 1'b1, 4'd0, 64'h0, 2, 1'b0, 1'b1, K_ARB);
        run_frame("ackerr", 11'($urandom), 1'b0, 4'd2, {$urandom, $urandom}, -1, 1'b0, 1'b0, K_ACK);
        run_frame("post_ack", 11'($urandom), 1'b0, 4'd1, {$urandom, $urandom}, -1, 1'b0, 1'b1, K_DONE);
        run_frame("biterr", 11'($urandom), 1'b0, 4'd3, {$urandom, $urandom}, 15, 1'b1, 1'b1, K_BIT);
        reset_mid_data();
        for (int i = 0; i < 3; i++) begin
            run_frame($sformatf("rnd%0d", i), 11'($urandom), 1'($urandom % 4 == 0), 4'($urandom),
                      {$urandom, $urandom}, -1, 1'b0, 1'b1, K_DONE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
